wb_commit_stage: RTL

Parametrised writeback/commit stage for the LoongArch-style 5-stage pipeline. It replaces the single-cause WB logic with the following:
- full exception prioritisation (interrupt, ADEF, INE, SYS, BRK, ALE, ADEM) to ecode/esubcode, plus BADV capture;
- register write suppression on excepting instructions;
- a configurable post-flush squash window;
- a retired-instruction counter.

It sits between the MEM stage and the register file / CSR unit, and drives pipeline flush to IF/ID/EX/MEM.

---
 rtl/wb_commit_stage_if.sv | 33 +++
 rtl/wb_commit_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage_if.sv
// MEM -> WB handoff bundle.
// master: MEM stage (drives ms_* fields, sees ws_allowin)
// slave : WB commit stage (consumes ms_* fields, drives ws_allowin)
interface wb_commit_stage_if #(
   parameter int DATA_W = 32,
   parameter int RF_AW  = 5
);
   logic              ms_to_ws_valid;
   logic              ws_allowin;
   logic [DATA_W-1:0] ms_pc;
   logic              ms_gr_we;
   logic [RF_AW-1:0]  ms_dest;
   logic [DATA_W-1:0] ms_result;
   logic              ms_csr_we;
   logic              ms_csr_rd;
   logic [13:0]       ms_csr_num;
   logic [DATA_W-1:0] ms_csr_wmask;
   logic              ms_ertn;
   logic [5:0]        ms_ex_cause;
   logic [DATA_W-1:0] ms_badv;

   modport master (
      output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_we,
             ms_csr_rd, ms_csr_num, ms_csr_wmask, ms_ertn, ms_ex_cause, ms_badv,
      input  ws_allowin
   );

   modport slave (
      input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_we,
             ms_csr_rd, ms_csr_num, ms_csr_wmask, ms_ertn, ms_ex_cause, ms_badv,
      output ws_allowin
   );
endinterface

// File: rtl/wb_commit_stage.sv
// Writeback / commit stage. Latches the MEM-stage instruction, prioritises
// exceptions into ECODE/ESUBCODE/BADV, suppresses GR/CSR writes on excepting
// instructions, raises flush on exception or ertn, squashes incoming
// instructions for FLUSH_CYCLES cycles after a flush and counts retirements.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ms                    MEM->WB bundle (slave side)
//   has_int               pending enabled interrupt
//   csr_rvalue            CSR read data (for csr_rd instructions)
//   ex_entry, era_entry   exception entry / return address
//   rf_*                  register-file write port
//   csr_*                 CSR access
//   ex_*                  exception commit info for the CSR unit
//   ertn_commit           ertn retired this cycle
//   flush, flush_target   pipeline redirect
//   ws_csr_busy           CSR instruction in WB (ID stall)
//   ws_fwd_dest/value     GR forwarding, zero when no GR write
//   retire_cnt            committed-instruction counter
//
// state  | meaning
// S_RUN  | normal operation, incoming instructions become valid
// S_HOLD | post-flush window, incoming instructions are discarded
module wb_commit_stage #(
   parameter int DATA_W       = 32,
   parameter int RF_AW        = 5,
   parameter int FLUSH_CYCLES = 1,
   parameter int PERF_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   wb_commit_stage_if.slave  ms,
   input  logic              has_int,
   input  logic [DATA_W-1:0] csr_rvalue,
   input  logic [DATA_W-1:0] ex_entry,
   input  logic [DATA_W-1:0] era_entry,
   output logic              rf_we,
   output logic [RF_AW-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [13:0]       csr_num,
   output logic              csr_we,
   output logic [DATA_W-1:0] csr_wmask,
   output logic [DATA_W-1:0] csr_wvalue,
   output logic              ex_commit,
   output logic [5:0]        ex_ecode,
   output logic [8:0]        ex_esubcode,
   output logic [DATA_W-1:0] ex_pc,
   output logic              ex_badv_we,
   output logic [DATA_W-1:0] ex_badv,
   output logic              ertn_commit,
   output logic              flush,
   output logic [DATA_W-1:0] flush_target,
   output logic              ws_csr_busy,
   output logic [RF_AW-1:0]  ws_fwd_dest,
   output logic [DATA_W-1:0] ws_fwd_value,
   output logic [PERF_W-1:0] retire_cnt
);

   localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

   typedef enum logic {S_RUN, S_HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  hold_cnt;

   logic              ws_valid;
   logic [DATA_W-1:0] ws_pc;
   logic              ws_gr_we;
   logic [RF_AW-1:0]  ws_dest;
   logic [DATA_W-1:0] ws_result;
   logic              ws_csr_we;
   logic              ws_csr_rd;
   logic [13:0]       ws_csr_num;
   logic [DATA_W-1:0] ws_csr_wmask;
   logic              ws_ertn;
   logic [5:0]        ws_ex_cause;
   logic [DATA_W-1:0] ws_badv;

   logic              ex;

   // ready_go is constant 1, so WB never back-pressures MEM.
   assign ms.ws_allowin = 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_RUN;
         hold_cnt     <= '0;
         ws_valid     <= 1'b0;
         ws_pc        <= '0;
         ws_gr_we     <= 1'b0;
         ws_dest      <= '0;
         ws_result    <= '0;
         ws_csr_we    <= 1'b0;
         ws_csr_rd    <= 1'b0;
         ws_csr_num   <= '0;
         ws_csr_wmask <= '0;
         ws_ertn      <= 1'b0;
         ws_ex_cause  <= '0;
         ws_badv      <= '0;
         retire_cnt   <= '0;
      end else begin
         ws_valid <= (state == S_RUN) ? ms.ms_to_ws_valid : 1'b0;
         if (ms.ms_to_ws_valid) begin
            ws_pc        <= ms.ms_pc;
            ws_gr_we     <= ms.ms_gr_we;
            ws_dest      <= ms.ms_dest;
            ws_result    <= ms.ms_result;
            ws_csr_we    <= ms.ms_csr_we;
            ws_csr_rd    <= ms.ms_csr_rd;
            ws_csr_num   <= ms.ms_csr_num;
            ws_csr_wmask <= ms.ms_csr_wmask;
            ws_ertn      <= ms.ms_ertn;
            ws_ex_cause  <= ms.ms_ex_cause;
            ws_badv      <= ms.ms_badv;
         end

         if (ws_valid && !ex)
            retire_cnt <= retire_cnt + PERF_W'(1);

         case (state)
            S_RUN: begin
               if (flush && (FLUSH_CYCLES > 0)) begin
                  state    <= S_HOLD;
                  hold_cnt <= CNT_W'(FLUSH_CYCLES);
               end
            end
            S_HOLD: begin
               if (hold_cnt <= CNT_W'(1)) begin
                  state    <= S_RUN;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt - CNT_W'(1);
               end
            end
            default: begin
               state    <= S_RUN;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   assign ex = ws_valid & (has_int | (|ws_ex_cause));

   // Priority: INT > ADEF > INE > SYS > BRK > ALE > ADEM.
   // Cause bits: {ADEM, ALE, BRK, SYS, INE, ADEF}.
   always_comb begin
      ex_ecode    = 6'h0;
      ex_esubcode = 9'h0;
      ex_badv_we  = 1'b0;
      ex_badv     = '0;
      if (ex) begin
         if (has_int) begin
            ex_ecode = 6'h0;
         end else if (ws_ex_cause[0]) begin
            ex_ecode   = 6'h8;
            ex_badv_we = 1'b1;
            ex_badv    = ws_pc;
         end else if (ws_ex_cause[1]) begin
            ex_ecode = 6'hd;
         end else if (ws_ex_cause[2]) begin
            ex_ecode = 6'hb;
         end else if (ws_ex_cause[3]) begin
            ex_ecode = 6'hc;
         end else if (ws_ex_cause[4]) begin
            ex_ecode   = 6'h9;
            ex_badv_we = 1'b1;
            ex_badv    = ws_badv;
         end else begin
            ex_ecode    = 6'h8;
            ex_esubcode = 9'h1;
            ex_badv_we  = 1'b1;
            ex_badv     = ws_badv;
         end
      end
   end

   assign ex_commit    = ex;
   assign ex_pc        = ws_pc;
   assign ertn_commit  = ws_valid & ws_ertn & ~ex;

   assign rf_we        = ws_valid & ws_gr_we & ~ex;
   assign rf_waddr     = ws_dest;
   assign rf_wdata     = ws_csr_rd ? csr_rvalue : ws_result;

   assign csr_num      = ws_csr_num;
   assign csr_we       = ws_valid & ws_csr_we & ~ex;
   assign csr_wmask    = ws_csr_wmask;
   assign csr_wvalue   = ws_result;

   assign flush        = ex | ertn_commit;
   assign flush_target = ex ? ex_entry : (ertn_commit ? era_entry : '0);

   assign ws_csr_busy  = ws_valid & (ws_csr_we | ws_csr_rd | ws_ertn);
   assign ws_fwd_dest  = rf_we ? ws_dest : '0;
   assign ws_fwd_value = rf_we ? rf_wdata : '0;

endmodule
